// File: rtl/uart_stream_fifo.sv
// Byte-stream FIFO with first-word-fall-through read, flush, watermarks and error/peak tracking.
// One-cycle write-to-read latency; writes are refused while full and reads while empty, with both counted as errors.
module uart_stream_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic [WIDTH-1:0]      i_Byte,
  input  logic                  i_Append_Now,
  output logic                  o_Ready_To_Write,
  output logic [WIDTH-1:0]      o_Byte,
  input  logic                  i_Shift_Now,
  output logic                  o_Ready_To_Read,
  input  logic                  i_Flush,
  input  logic                  i_Clear_Errors,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic [DEPTH_LOG2:0]   o_Free_Space,
  output logic                  o_Almost_Full,
  output logic                  o_Almost_Empty,
  output logic                  o_Overflow,
  output logic                  o_Underflow,
  output logic [7:0]            o_Drop_Count,
  output logic [DEPTH_LOG2:0]   o_Peak_Count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         peak_q, peak_d;
  logic [CW-1:0]         peak_base;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [7:0]            drop_q, drop_d;
  logic [7:0]            drop_base;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic                  ovf_evt, udf_evt;

  // Acceptance looks only at the pre-edge count, so a full FIFO cannot take
  // a write even when a read frees a slot in the same cycle.
  always_comb begin
    full    = (count_q == DEPTH_C);
    empty   = (count_q == '0);
    wr_acc  = i_Append_Now & ~full  & ~i_Flush;
    rd_acc  = i_Shift_Now  & ~empty & ~i_Flush;
    ovf_evt = i_Append_Now & full   & ~i_Flush;
    udf_evt = i_Shift_Now  & empty  & ~i_Flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(wr_acc);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(rd_acc);
    count_d  = count_q;
    if (i_Flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Clearing happens first so that an error in the same cycle still lands.
  always_comb begin
    ovf_d     = ovf_evt | (ovf_q & ~i_Clear_Errors);
    udf_d     = udf_evt | (udf_q & ~i_Clear_Errors);
    drop_base = i_Clear_Errors ? 8'd0 : drop_q;
    drop_d    = drop_base;
    if (ovf_evt && (drop_base != 8'hFF)) begin
      drop_d = drop_base + 8'd1;
    end
    peak_base = i_Clear_Errors ? '0 : peak_q;
    peak_d    = (count_d > peak_base) ? count_d : peak_base;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      peak_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      peak_q   <= peak_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= i_Byte;
    end
  end

  assign o_Byte           = mem_q[rd_ptr_q];
  assign o_Ready_To_Write = ~full;
  assign o_Ready_To_Read  = ~empty;
  assign o_Count          = count_q;
  assign o_Free_Space     = DEPTH_C - count_q;
  assign o_Almost_Full    = (count_q >= AF_C);
  assign o_Almost_Empty   = (count_q <= AE_C);
  assign o_Overflow       = ovf_q;
  assign o_Underflow      = udf_q;
  assign o_Drop_Count     = drop_q;
  assign o_Peak_Count     = peak_q;

endmodule

// File: tb/tb_uart_stream_fifo.sv
// Scoreboard bench for uart_stream_fifo: a queue-based model predicts popped bytes and per-cycle status.
module tb_uart_stream_fifo;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic       clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic [7:0] i_Byte = 8'd0;
  logic       i_Append_Now = 1'b0;
  logic       i_Shift_Now = 1'b0;
  logic       i_Flush = 1'b0;
  logic       i_Clear_Errors = 1'b0;
  logic       o_Ready_To_Write, o_Ready_To_Read;
  logic [7:0] o_Byte;
  logic [3:0] o_Count, o_Free_Space, o_Peak_Count;
  logic       o_Almost_Full, o_Almost_Empty, o_Overflow, o_Underflow;
  logic [7:0] o_Drop_Count;

  uart_stream_fifo #(.WIDTH(8), .DEPTH_LOG2(3), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .i_Clk(clk), .i_Rst_L(i_Rst_L), .i_Byte(i_Byte), .i_Append_Now(i_Append_Now),
    .o_Ready_To_Write(o_Ready_To_Write), .o_Byte(o_Byte), .i_Shift_Now(i_Shift_Now),
    .o_Ready_To_Read(o_Ready_To_Read), .i_Flush(i_Flush), .i_Clear_Errors(i_Clear_Errors),
    .o_Count(o_Count), .o_Free_Space(o_Free_Space), .o_Almost_Full(o_Almost_Full),
    .o_Almost_Empty(o_Almost_Empty), .o_Overflow(o_Overflow), .o_Underflow(o_Underflow),
    .o_Drop_Count(o_Drop_Count), .o_Peak_Count(o_Peak_Count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit ovf;
    bit udf;
    int drop;
    int peak;
  } st_t;

  int         tests = 0;
  int         fails = 0;
  bit         mon_en = 1'b0;
  st_t        stat_q[$];
  logic [7:0] exp_dat[$];

  // Reference model: FIFO contents as a plain queue plus error bookkeeping.
  logic [7:0] mq[$];
  bit         m_ovf, m_udf;
  int         m_drop, m_peak;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic st_t snap();
    st_t s;
    s.cnt  = mq.size();
    s.ovf  = m_ovf;
    s.udf  = m_udf;
    s.drop = m_drop;
    s.peak = m_peak;
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    i_Rst_L = 1'b0;
    i_Append_Now = 1'b0; i_Shift_Now = 1'b0; i_Flush = 1'b0; i_Clear_Errors = 1'b0;
    mq.delete();
    m_ovf = 0; m_udf = 0; m_drop = 0; m_peak = 0;
    stat_q.delete();
    stat_q.push_back(snap());
    stat_q.push_back(snap());
    mon_en = 1'b1;
  endtask

  task automatic step(input bit app, input bit shf, input logic [7:0] d, input bit fl, input bit clr);
    int  c;
    bit  ovf_ev, udf_ev;
    @(negedge clk);
    i_Rst_L = 1'b1;
    i_Append_Now = app; i_Shift_Now = shf; i_Byte = d;
    i_Flush = fl; i_Clear_Errors = clr;
    c = mq.size();
    ovf_ev = 0; udf_ev = 0;
    if (fl) begin
      mq.delete();
    end else begin
      ovf_ev = app && (c == DEPTH);
      udf_ev = shf && (c == 0);
      if (shf && c > 0) exp_dat.push_back(mq.pop_front());
      if (app && c < DEPTH) mq.push_back(d);
    end
    if (clr) begin
      m_ovf = 0; m_udf = 0; m_drop = 0; m_peak = 0;
    end
    if (ovf_ev) begin
      m_ovf = 1;
      if (m_drop < 255) m_drop++;
    end
    if (udf_ev) m_udf = 1;
    if (mq.size() > m_peak) m_peak = mq.size();
    stat_q.push_back(snap());
  endtask

  // Monitor: checks status every cycle and o_Byte whenever a pop is presented.
  always begin
    st_t s;
    @(negedge clk);
    #4;
    if (mon_en) begin
      if (stat_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL status_queue: got empty expected an entry at %0t", $time);
      end else begin
        s = stat_q.pop_front();
        chk("count", 32'(o_Count), 32'(s.cnt));
        chk("free_space", 32'(o_Free_Space), 32'(DEPTH - s.cnt));
        chk("ready_to_write", 32'(o_Ready_To_Write), 32'(s.cnt < DEPTH));
        chk("ready_to_read", 32'(o_Ready_To_Read), 32'(s.cnt > 0));
        chk("almost_full", 32'(o_Almost_Full), 32'(s.cnt >= AF));
        chk("almost_empty", 32'(o_Almost_Empty), 32'(s.cnt <= AE));
        chk("overflow", 32'(o_Overflow), 32'(s.ovf));
        chk("underflow", 32'(o_Underflow), 32'(s.udf));
        chk("drop_count", 32'(o_Drop_Count), 32'(s.drop));
        chk("peak_count", 32'(o_Peak_Count), 32'(s.peak));
      end
      if (i_Rst_L && i_Shift_Now && o_Ready_To_Read && !i_Flush) begin
        if (exp_dat.size() == 0) begin
          tests++; fails++;
          $display("FAIL data_pop: got 0x%0h with no byte expected at %0t", o_Byte, $time);
        end else begin
          chk("data", 32'(o_Byte), 32'(exp_dat.pop_front()));
        end
      end
    end
  end

  initial begin
    int written;
    int cyc;
    bit a;
    do_reset();
    // Reset in the middle of a fill.
    for (int i = 0; i < 5; i++) step(1, 0, 8'h10 + 8'(i), 0, 0);
    do_reset();
    step(0, 0, 8'h00, 0, 0);
    // Fill to full, then three rejected appends.
    for (int i = 0; i < 8; i++) step(1, 0, 8'h41 + 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'hE0 + 8'(i), 0, 0);
    // Drain in order, then one shift on empty.
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    // Simultaneous append/shift on full and on empty.
    for (int i = 0; i < 8; i++) step(1, 0, 8'h50 + 8'(i), 0, 0);
    step(1, 1, 8'hAA, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 8'h00, 0, 0);
    step(1, 1, 8'hBB, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    // Twenty writes draining one per two cycles, wrapping the pointers.
    written = 0;
    cyc = 0;
    while ((written < 20 || mq.size() > 0) && cyc < 200) begin
      a = (written < 20) && (mq.size() < DEPTH);
      step(a, cyc[0], 8'h80 + 8'(written), 0, 0);
      if (a) written++;
      cyc++;
    end
    // Flush with a same-cycle append, then clear errors.
    for (int i = 0; i < 4; i++) step(1, 0, 8'h30 + 8'(i), 0, 0);
    step(1, 1, 8'hCC, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 0);
    // Clear coinciding with an underflow: the error wins.
    step(0, 1, 8'h00, 0, 1);
    // Drop counter saturation.
    for (int i = 0; i < 8; i++) step(1, 0, 8'(i), 0, 0);
    for (int i = 0; i < 260; i++) step(1, 0, 8'hF0, 0, 0);
    step(1, 0, 8'hF1, 0, 1);
    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 8'($urandom),
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3);
      if ($urandom_range(0, 999) < 2) do_reset();
    end
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    @(negedge clk);
    mon_en = 1'b0;
    chk("pending_bytes", 32'(exp_dat.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
